ram_port_arbiter: RTL and testbench

- Shares the single-port 4-bit data RAM between two masters: the uP core (CPU port) and an external loader/debug port (EXT port).
- Each cycle, registered arbitration decides which request drives RAM chip-select, write-enable, address and write data.
- Read data is steered back to the winning port.
- CPU has default priority. EXT has a starvation guard and a lock mode for atomic bursts, with a forced-release timeout.

---
 rtl/ram_arb_pkg.sv | 13 +
 rtl/ram_port_arbiter_if.sv | 51 +++++
 rtl/sat_counter.sv | 39 +++
 rtl/ram_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the RAM port arbiter.
package ram_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 12;
  localparam int unsigned DEF_DATA_W = 4;

  // Arbitration state; LOCKED persists even on cycles where EXT issues no access.
  typedef enum logic [1:0] {IDLE, CPU, EXT, LOCKED} arb_state_t;

  // Which port the read data returning this cycle belongs to.
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_EXT} owner_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// CPU, EXT and RAM-side signals of the arbiter. The arbiter takes the slave view;
// the requesting masters and the RAM model take the master view.
interface ram_port_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              ext_req;
  logic              ext_we;
  logic              ext_lock;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_gnt;
  logic              ext_rvalid;
  logic [DATA_W-1:0] ext_rdata;

  logic              ram_cs;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
    output ram_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  ram_cs, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
    input  ram_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output ext_gnt, ext_rvalid, ext_rdata,
    output ram_cs, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int unsigned MAX = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);

  localparam int unsigned W = $clog2(MAX + 1);
  localparam logic [W-1:0] MaxVal = W'(MAX);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_cnt_d;

  // Next count: clear, else step up until the ceiling.
  always_comb begin
    w_cnt_d = r_cnt;
    if (i_clr) begin
      w_cnt_d = '0;
    end else if (i_inc && (r_cnt != MaxVal)) begin
      w_cnt_d = r_cnt + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

  assign o_at_max = (r_cnt == MaxVal);

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares a single-port RAM between the CPU and the EXT loader/debug port.
// Decisions are made on sampled requests and issued to the RAM one cycle later;
// read data is steered back one cycle after that.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned LOCK_MAX   = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  ram_port_arbiter_if.slave  bus,
  output logic               o_lock_timeout
);

  arb_state_t        r_state;
  arb_state_t        w_state_d;
  owner_t            r_owner;
  owner_t            w_owner_d;
  logic              r_cpu_gnt;
  logic              r_ext_gnt;
  logic              r_ram_cs;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_timeout;
  logic              r_armed;

  logic              w_locked;
  logic              w_force;
  logic              w_cpu_win;
  logic              w_ext_win;
  logic              w_we_d;
  logic [ADDR_W-1:0] w_addr_d;
  logic [DATA_W-1:0] w_wdata_d;
  logic              w_armed_d;
  logic              w_starve_at_max;
  logic              w_lock_at_max;

  // Lock counter holds the number of LOCKED cycles so far, so reaching the
  // ceiling while ext_lock is still high forces the release.
  assign w_locked = (r_state == LOCKED);
  assign w_force  = w_locked && bus.ext_lock && w_lock_at_max;

  // Winner selection and next arbitration state.
  always_comb begin
    w_cpu_win = 1'b0;
    w_ext_win = 1'b0;
    w_state_d = IDLE;
    if (w_locked && bus.ext_lock && !w_force) begin
      w_ext_win = bus.ext_req;
      w_state_d = LOCKED;
    end else begin
      if (bus.ext_req && w_starve_at_max) begin
        w_ext_win = 1'b1;
      end else if (bus.cpu_req) begin
        w_cpu_win = 1'b1;
      end else if (bus.ext_req) begin
        w_ext_win = 1'b1;
      end
      if (w_cpu_win) begin
        w_state_d = CPU;
      end else if (w_ext_win) begin
        // The forced-release cycle must not immediately re-take the lock.
        w_state_d = (bus.ext_lock && r_armed && !w_force) ? LOCKED : EXT;
      end
    end
  end

  // Access fields of the winning port; zero when nobody is issued.
  always_comb begin
    w_we_d    = 1'b0;
    w_addr_d  = '0;
    w_wdata_d = '0;
    if (w_cpu_win) begin
      w_we_d    = bus.cpu_we;
      w_addr_d  = bus.cpu_addr;
      w_wdata_d = bus.cpu_wdata;
    end else if (w_ext_win) begin
      w_we_d    = bus.ext_we;
      w_addr_d  = bus.ext_addr;
      w_wdata_d = bus.ext_wdata;
    end
  end

  // Re-arm tracking and read-return ownership for the access now on the RAM.
  always_comb begin
    w_armed_d = r_armed;
    if (w_force) begin
      w_armed_d = 1'b0;
    end else if (!bus.ext_lock) begin
      w_armed_d = 1'b1;
    end
    w_owner_d = OWN_NONE;
    if (r_cpu_gnt && !r_ram_we) begin
      w_owner_d = OWN_CPU;
    end else if (r_ext_gnt && !r_ram_we) begin
      w_owner_d = OWN_EXT;
    end
  end

  // Registered grant, RAM command and bookkeeping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_owner     <= OWN_NONE;
      r_cpu_gnt   <= 1'b0;
      r_ext_gnt   <= 1'b0;
      r_ram_cs    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_timeout   <= 1'b0;
      r_armed     <= 1'b1;
    end else begin
      r_state     <= w_state_d;
      r_owner     <= w_owner_d;
      r_cpu_gnt   <= w_cpu_win;
      r_ext_gnt   <= w_ext_win;
      r_ram_cs    <= w_cpu_win || w_ext_win;
      r_ram_we    <= w_we_d;
      r_ram_addr  <= w_addr_d;
      r_ram_wdata <= w_wdata_d;
      r_timeout   <= w_force;
      r_armed     <= w_armed_d;
    end
  end

  sat_counter #(
    .MAX (STARVE_MAX)
  ) u_starve_cnt (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_inc    (bus.ext_req && !w_ext_win),
    .i_clr    (!bus.ext_req || w_ext_win),
    .o_at_max (w_starve_at_max)
  );

  sat_counter #(
    .MAX (LOCK_MAX)
  ) u_lock_cnt (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_inc    (w_state_d == LOCKED),
    .i_clr    (w_state_d != LOCKED),
    .o_at_max (w_lock_at_max)
  );

  assign bus.cpu_gnt    = r_cpu_gnt;
  assign bus.ext_gnt    = r_ext_gnt;
  assign bus.ram_cs     = r_ram_cs;
  assign bus.ram_we     = r_ram_we;
  assign bus.ram_addr   = r_ram_addr;
  assign bus.ram_wdata  = r_ram_wdata;
  assign bus.cpu_rvalid = (r_owner == OWN_CPU);
  assign bus.ext_rvalid = (r_owner == OWN_EXT);
  assign bus.cpu_rdata  = (r_owner == OWN_CPU) ? bus.ram_rdata : '0;
  assign bus.ext_rdata  = (r_owner == OWN_EXT) ? bus.ram_rdata : '0;
  assign o_lock_timeout = r_timeout;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed scenarios plus a random phase, all checked every cycle against a
// rule-level model of the arbiter.
module tb_ram_port_arbiter;

  localparam int unsigned ADDR_W     = 12;
  localparam int unsigned DATA_W     = 4;
  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned LOCK_MAX   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lock_timeout;
  int   checks = 0;
  int   errors = 0;

  ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_port_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .STARVE_MAX (STARVE_MAX),
    .LOCK_MAX   (LOCK_MAX)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .bus            (bus),
    .o_lock_timeout (lock_timeout)
  );

  always #5 clk = ~clk;

  // Model state: losses in a row, locked flag, cycles spent locked, lock permitted.
  int unsigned m_starve, m_age, e_own, n_own;
  bit          m_locked, m_armed;
  // Expected outputs for the current cycle (e_) and the next one (n_).
  bit          e_cpu_gnt, e_ext_gnt, e_cs, e_we, e_to;
  bit          n_cpu_gnt, n_ext_gnt, n_cs, n_we, n_to;
  logic [11:0] e_addr, n_addr;
  logic [3:0]  e_wdata, n_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_starve = 0; m_age = 0; m_locked = 0; m_armed = 1;
    e_cpu_gnt = 0; e_ext_gnt = 0; e_cs = 0; e_we = 0; e_to = 0;
    e_addr = '0; e_wdata = '0; e_own = 0;
  endtask

  task automatic drive_cpu(input logic req, input logic we, input logic [11:0] addr,
                           input logic [3:0] wd);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
  endtask

  task automatic drive_ext(input logic req, input logic we, input logic lock,
                           input logic [11:0] addr, input logic [3:0] wd);
    bus.ext_req = req; bus.ext_we = we; bus.ext_lock = lock;
    bus.ext_addr = addr; bus.ext_wdata = wd;
  endtask

  task automatic set_idle();
    drive_cpu(0, 0, 12'h0, 4'h0);
    drive_ext(0, 0, 0, 12'h0, 4'h0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cpu_gnt"}, 32'(bus.cpu_gnt), 0);
    chk({tag, "_ext_gnt"}, 32'(bus.ext_gnt), 0);
    chk({tag, "_ram_cs"}, 32'(bus.ram_cs), 0);
    chk({tag, "_ram_we"}, 32'(bus.ram_we), 0);
    chk({tag, "_ram_addr"}, 32'(bus.ram_addr), 0);
    chk({tag, "_ram_wdata"}, 32'(bus.ram_wdata), 0);
    chk({tag, "_cpu_rvalid"}, 32'(bus.cpu_rvalid), 0);
    chk({tag, "_cpu_rdata"}, 32'(bus.cpu_rdata), 0);
    chk({tag, "_ext_rvalid"}, 32'(bus.ext_rvalid), 0);
    chk({tag, "_ext_rdata"}, 32'(bus.ext_rdata), 0);
    chk({tag, "_lock_timeout"}, 32'(lock_timeout), 0);
  endtask

  task automatic check_all();
    chk("cpu_gnt", 32'(bus.cpu_gnt), 32'(e_cpu_gnt));
    chk("ext_gnt", 32'(bus.ext_gnt), 32'(e_ext_gnt));
    chk("ram_cs", 32'(bus.ram_cs), 32'(e_cs));
    chk("lock_timeout", 32'(lock_timeout), 32'(e_to));
    if (e_cs) begin
      chk("ram_we", 32'(bus.ram_we), 32'(e_we));
      chk("ram_addr", 32'(bus.ram_addr), 32'(e_addr));
      chk("ram_wdata", 32'(bus.ram_wdata), 32'(e_wdata));
    end
    chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(e_own == 1));
    chk("cpu_rdata", 32'(bus.cpu_rdata), (e_own == 1) ? 32'(bus.ram_rdata) : 32'd0);
    chk("ext_rvalid", 32'(bus.ext_rvalid), 32'(e_own == 2));
    chk("ext_rdata", 32'(bus.ext_rdata), (e_own == 2) ? 32'(bus.ram_rdata) : 32'd0);
  endtask

  // Apply the arbitration rules to this cycle's inputs.
  task automatic decide();
    bit cw = 0;
    bit ew = 0;
    bit force_rel = m_locked && bus.ext_lock && (m_age == LOCK_MAX);
    bit hold = m_locked && bus.ext_lock && !force_rel;
    if (hold) ew = bus.ext_req;
    else if (bus.ext_req && (m_starve == STARVE_MAX)) ew = 1;
    else if (bus.cpu_req) cw = 1;
    else if (bus.ext_req) ew = 1;
    n_own = (e_cpu_gnt && !e_we) ? 1 : ((e_ext_gnt && !e_we) ? 2 : 0);
    n_cpu_gnt = cw; n_ext_gnt = ew; n_cs = cw || ew; n_to = force_rel;
    n_we    = cw ? bus.cpu_we    : bus.ext_we;
    n_addr  = cw ? bus.cpu_addr  : bus.ext_addr;
    n_wdata = cw ? bus.cpu_wdata : bus.ext_wdata;
    if (!bus.ext_req || ew) m_starve = 0;
    else if (m_starve < STARVE_MAX) m_starve++;
    if (hold || (ew && bus.ext_lock && m_armed && !force_rel)) begin
      m_locked = 1; m_age++;
    end else begin
      m_locked = 0; m_age = 0;
    end
    if (force_rel) m_armed = 0;
    else if (!bus.ext_lock) m_armed = 1;
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    decide();
    @(posedge clk);
    #1;
    e_cpu_gnt = n_cpu_gnt; e_ext_gnt = n_ext_gnt; e_cs = n_cs; e_we = n_we; e_to = n_to;
    e_addr = n_addr; e_wdata = n_wdata; e_own = n_own;
    bus.ram_rdata = 4'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, first, last, pulses, run, max_run;
    bit lk;
    set_idle();
    bus.ram_rdata = 4'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    // Idle: nothing issued, nothing returned.
    repeat (10) tick();

    // CPU read latency.
    drive_cpu(1, 0, 12'h0A5, 4'h0);
    tick();
    drive_cpu(0, 0, 12'h0, 4'h0);
    chk("lat_gnt", 32'(bus.cpu_gnt), 1);
    chk("lat_cs", 32'(bus.ram_cs), 1);
    chk("lat_addr", 32'(bus.ram_addr), 32'h0A5);
    tick();
    bus.ram_rdata = 4'h7;
    #1;
    chk("lat_rvalid", 32'(bus.cpu_rvalid), 1);
    chk("lat_rdata", 32'(bus.cpu_rdata), 32'h7);
    tick();

    // Starvation guard: CPU x4 then EXT, repeating.
    drive_cpu(1, 0, 12'h010, 4'h0);
    drive_ext(1, 0, 0, 12'h020, 4'h0);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("starve_pattern", 32'(bus.ext_gnt), 32'(((i + 1) % 5) == 0));
    end

    // Locked burst of three EXT writes with the CPU requesting throughout.
    k = 0; first = -1; last = -1;
    for (int c = 0; c < 30 && k < 3; c++) begin
      drive_ext(1, 1, 1, 12'h200 + 12'(k), 4'(k + 1));
      tick();
      if (e_ext_gnt) begin
        if (first < 0) first = c;
        last = c;
        chk("burst_addr", 32'(bus.ram_addr), 32'h200 + 32'(k));
        chk("burst_wdata", 32'(bus.ram_wdata), 32'(k + 1));
        k++;
      end
    end
    chk("burst_done", 32'(k), 3);
    chk("burst_consecutive", 32'(last - first), 2);
    drive_ext(0, 0, 0, 12'h0, 4'h0);
    tick();
    chk("burst_release_cpu", 32'(bus.cpu_gnt), 1);

    // Lock timeout with ext_lock held high.
    drive_ext(1, 0, 1, 12'h300, 4'h5);
    pulses = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (lock_timeout === 1'b1) begin
        pulses++;
        chk("timeout_cpu_gnt", 32'(bus.cpu_gnt), 1);
      end
    end
    chk("timeout_pulses", 32'(pulses), 1);
    // Re-arm: ext_lock low for one cycle, then a lock can be taken again.
    drive_ext(1, 0, 0, 12'h300, 4'h5);
    tick();
    drive_ext(1, 0, 1, 12'h301, 4'h5);
    run = 0; max_run = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      run = (bus.ext_gnt === 1'b1) ? run + 1 : 0;
      if (run > max_run) max_run = run;
    end
    chk("relock_run", 32'(max_run >= 2), 1);

    // Random traffic.
    lk = 0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 7) == 0) lk = !lk;
      drive_cpu(1'($urandom_range(0, 3) != 0), 1'($urandom), 12'($urandom), 4'($urandom));
      drive_ext(1'($urandom_range(0, 2) != 0), 1'($urandom), lk, 12'($urandom),
                4'($urandom));
      tick();
    end

    // Reset during an outstanding read.
    set_idle();
    repeat (3) tick();
    drive_cpu(1, 0, 12'h123, 4'h0);
    tick();
    drive_cpu(0, 0, 12'h0, 4'h0);
    chk("midrd_gnt", 32'(bus.cpu_gnt), 1);
    rst_n = 1'b0;
    #1;
    chk_zero("midrd_reset");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("midrd_no_rvalid", 32'(bus.cpu_rvalid), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
